photo_transition_ctrl: RTL

//  Control stage directly upstream of the photo-frame pixel mux. Debounces the split/pause buttons and runs
//  the transition FSM: continuous vertical scroll, vertical split-open, horizontal split-open, blank hold.

---
 rtl/photo_transition_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/photo_transition_ctrl.sv
// rtl/photo_transition_ctrl.sv - button debounce, step tick and transition FSM ahead of the photo-frame pixel mux
//
// Ports:
//   clk, rst               system clock; asynchronous active-high reset
//   btn_split, btn_pause   raw asynchronous push-buttons, active-high
//   mode                   0=SCROLL 1=VSPLIT 2=HSPLIT 3=HOLD (display blanks in HOLD)
//   scroll_pos             vertical image offset in rows, 0..IMG_H-1
//   split_off              split opening in display pixels, 0..limit of current split
//   busy                   high while a split or hold is in progress
//   done                   one-cycle pulse when split_off reaches its limit
//   paused                 current pause state (masks step ticks only)
module photo_transition_ctrl #(
    parameter int STEP_DIV   = 4194304,
    parameter int DB_CYCLES  = 1000000,
    parameter int IMG_H      = 240,
    parameter int V_LIMIT    = 240,
    parameter int H_LIMIT    = 320,
    parameter int SPLIT_STEP = 2,
    parameter int HOLD_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_split,
    input  logic       btn_pause,
    output logic [1:0] mode,
    output logic [8:0] scroll_pos,
    output logic [8:0] split_off,
    output logic       busy,
    output logic       done,
    output logic       paused
);

    localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {
        S_SCROLL = 2'd0,
        S_VSPLIT = 2'd1,
        S_HSPLIT = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // Button path, index 0 = split, index 1 = pause
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [1:0]      pulse;
    logic [DB_W-1:0] db_cnt [2];

    assign raw = {btn_pause, btn_split};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    // Level accepted; only a newly accepted press produces a pulse
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                    pulse[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Free-running step tick; keeps counting while paused
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_W'(STEP_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    // Transition FSM
    state_t            state;
    logic              next_h;
    logic [HOLD_W-1:0] hold_cnt;
    logic              step;
    logic [8:0]        split_lim;
    logic [9:0]        split_sum;
    logic [8:0]        split_nxt;

    assign step      = tick & ~paused;
    assign split_lim = (state == S_HSPLIT) ? 9'(H_LIMIT) : 9'(V_LIMIT);
    // Extra bit so the saturating add cannot wrap near the 9-bit ceiling
    assign split_sum = {1'b0, split_off} + 10'(SPLIT_STEP);
    assign split_nxt = (split_sum >= {1'b0, split_lim}) ? split_lim : split_sum[8:0];
    assign mode      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_SCROLL;
            scroll_pos <= '0;
            split_off  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            paused     <= 1'b0;
            next_h     <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (pulse[1]) begin
                paused <= ~paused;
            end
            case (state)
                S_SCROLL: begin
                    // A split request takes priority over a coincident tick
                    if (pulse[0]) begin
                        state     <= next_h ? S_HSPLIT : S_VSPLIT;
                        next_h    <= ~next_h;
                        split_off <= '0;
                        busy      <= 1'b1;
                    end else if (step) begin
                        scroll_pos <= (scroll_pos == 9'(IMG_H - 1)) ? '0 : scroll_pos + 9'd1;
                    end
                end
                S_VSPLIT, S_HSPLIT: begin
                    if (step) begin
                        split_off <= split_nxt;
                        if (split_nxt == split_lim) begin
                            done     <= 1'b1;
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (step) begin
                        if (hold_cnt == HOLD_W'(HOLD_TICKS - 1)) begin
                            state     <= S_SCROLL;
                            split_off <= '0;
                            busy      <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: state <= S_SCROLL;
            endcase
        end
    end

endmodule
